// File: rtl/fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch path.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] PC_INCR          = 32'd4;

    // One buffered fetch: address and the word read from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, instr} fetch records; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        head    = mem_q[rd_ptr_q];
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, redirect handling and a small
// decoupling buffer between instruction memory and decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_d;
    logic         fifo_full;
    logic         fifo_empty;
    logic         do_push;
    logic         do_pop;
    fetch_entry_t head;
    fetch_entry_t wr_entry;

    // Handshake and next-PC selection; redirect beats sequential fetch.
    always_comb begin
        do_pop     = out_valid & out_ready;
        do_push    = ~redirect & (~fifo_full | do_pop);
        wr_entry   = '{pc: fetch_pc_q, instr: imem_rdata};
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = align_word(redirect_target);
        end else if (do_push) begin
            fetch_pc_d = fetch_pc_q + PC_INCR;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (do_push),
        .pop     (do_pop),
        .flush   (redirect),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    // Decode-side outputs; an empty buffer presents a NOP at address 0.
    always_comb begin
        imem_addr    = fetch_pc_q;
        out_valid    = ~fifo_empty;
        out_instr    = fifo_empty ? NOP_INSTR : head.instr;
        out_pc       = fifo_empty ? 32'h0 : head.pc;
        out_pc_plus4 = out_pc + PC_INCR;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, 2, entries in the fetch buffer; must be a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory (A).
REQ-006 SHALL have port imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle (RD).
REQ-007 SHALL have port redirect  input  1  taken branch/jump request (PCSrc).
REQ-008 SHALL have port redirect_target  input  32  new fetch address, valid when redirect=1.
REQ-009 SHALL have port out_valid  output  1  head instruction is available to decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts the head instruction this cycle.
REQ-011 SHALL have port out_instr  output  32  head instruction word.
REQ-012 SHALL have port out_pc  output  32  address of the head instruction.
REQ-013 SHALL have port out_pc_plus4  output  32  out_pc + 4, modulo 2^32.

Function
REQ-014 SHALL hold fetch_pc and drive imem_addr = fetch_pc at all times.
REQ-015 SHALL enqueue {fetch_pc, imem_rdata} and advance fetch_pc by 4 (wrap at 2^32) in each cycle where buffer count < DEPTH, or count == DEPTH with a dequeue, and redirect = 0.
REQ-016 SHALL hold fetch_pc and enqueue nothing while the buffer is full with no dequeue.
REQ-017 SHALL dequeue the head entry when out_valid & out_ready; simultaneous enqueue and dequeue leaves count unchanged.
REQ-018 SHALL drive out_valid = (count != 0), with out_instr/out_pc taken from the head entry; no same-cycle bypass, so fetch-to-out_valid latency is exactly 1 cycle.
REQ-019 SHALL drive out_instr = 32'h0000_0013 (NOP) and out_pc = 0 when out_valid = 0.
REQ-020 SHALL, on redirect = 1, clear the buffer to count 0, load fetch_pc = {redirect_target[31:2], 2'b00}, and enqueue nothing that cycle; redirect takes priority over every other event.
REQ-021 SHALL treat an out_ready handshake coinciding with redirect as consumed; the flush still empties the buffer.
REQ-022 SHALL, after a redirect, present the target's instruction with out_valid = 1 two cycles after the redirect cycle.
REQ-023 SHALL keep entries in strict program order; read and write pointers wrap modulo DEPTH.

Reset
REQ-024 SHALL, when reset = 1 at a clock edge, set fetch_pc = RESET_PC, count = 0, and both pointers = 0, overriding redirect and handshakes.
REQ-025 SHALL hold out_valid = 0, out_instr = NOP and out_pc = 0 in the cycle after reset is applied, and whenever the buffer is empty.
REQ-026 SHALL discard any buffered instructions when reset is asserted mid-stream.

Structure
REQ-027 SHALL place RESET_PC default, the NOP encoding (32'h0000_0013) and the PC increment (4) in the shared core constants package.
REQ-028 SHALL implement the buffer as one sub-module, fetch_fifo: a DEPTH x 64-bit FIFO with push, pop, flush, full, empty and head outputs.
REQ-029 SHALL keep all next-PC selection logic in fetch_unit, outside fetch_fifo.

Verification
REQ-030 Reset release with imem returning addr|0xA000_0000 and out_ready = 1 -> cycle 1 out_valid = 1, out_pc = 0, out_instr = 0xA000_0000; then out_pc = 4, 8, 12 on consecutive cycles.
REQ-031 out_ready = 0 for 5 cycles after reset -> count saturates at 2 and fetch_pc holds at 8; on out_ready = 1, out_pc sequence = 0, 4, 8 with none lost or duplicated.
REQ-032 redirect = 1, redirect_target = 0x0000_0103 while the buffer holds 2 entries -> next cycle out_valid = 0 and imem_addr = 0x100; the cycle after, out_pc = 0x100 and out_pc_plus4 = 0x104.
REQ-033 redirect_target = 0xFFFF_FFFC, out_ready = 1 -> out_pc sequence 0xFFFF_FFFC, 0x0000_0000, and out_pc_plus4 = 0x0000_0000 for the first entry.
REQ-034 reset = 1 asserted with a full buffer and redirect = 1 -> next cycle out_valid = 0, imem_addr = RESET_PC, and redirect is ignored.
REQ-035 Random out_ready, no redirect, 1000 cycles -> out_pc stream strictly increments by 4, never overflows or underflows the buffer, and out_valid never drops without a dequeue.
